// File: rtl/acondicionador_botones.sv
// acondicionador_botones: conditions four raw push-buttons (Test, Reset,
// Energia, Medicina). Each input is synchronized, debounced by its own FSM
// and turned into a clean level, a one-cycle press strobe and an optional
// long-press flag.
// Optional feature macro: ACONDICIONADOR_LONG_PRESS_EN enables the per-button
// hold counters and btn_long. Without it btn_long is tied low.
module acondicionador_botones #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn_raw,
    output logic [3:0] btn_level,
    output logic [3:0] btn_pulse,
    output logic [3:0] btn_long
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DEB_ONE = DW'(1);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEB_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        DEB_RELEASE = 2'd3
    } state_t;

    // Saturating increment: the debounce counter never wraps.
    function automatic logic [DW-1:0] deb_inc(input logic [DW-1:0] v);
        return (v >= DEB_MAX) ? v : v + 1'b1;
    endfunction

    logic [3:0] sync_p0;
    logic [3:0] sync_p1;

    // Two-flop synchronizer; the debouncers only ever look at sync_p1.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_bit
        state_t        state, state_next;
        logic [DW-1:0] deb_cnt, deb_cnt_next;
        logic [DW-1:0] deb_cnt_inc;
        logic          pulse_q, pulse_next;
        logic          level;

        assign deb_cnt_inc = deb_inc(deb_cnt);

        // State, debounce counter and press strobe registers.
        always_ff @(posedge clk) begin
            if (reset) begin
                state   <= IDLE;
                deb_cnt <= '0;
                pulse_q <= 1'b0;
            end else begin
                state   <= state_next;
                deb_cnt <= deb_cnt_next;
                pulse_q <= pulse_next;
            end
        end

        // Next-state logic; the count includes the sample that left the
        // previous stable state, so entry loads 1 rather than 0.
        always_comb begin
            state_next   = state;
            deb_cnt_next = deb_cnt;
            pulse_next   = 1'b0;
            case (state)
                IDLE: begin
                    deb_cnt_next = '0;
                    if (sync_p1[i]) begin
                        deb_cnt_next = DEB_ONE;
                        if (DEB_ONE == DEB_MAX) begin
                            state_next   = PRESSED;
                            deb_cnt_next = '0;
                            pulse_next   = 1'b1;
                        end else begin
                            state_next = DEB_PRESS;
                        end
                    end
                end
                DEB_PRESS: begin
                    if (!sync_p1[i]) begin
                        state_next   = IDLE;
                        deb_cnt_next = '0;
                    end else if (deb_cnt_inc == DEB_MAX) begin
                        state_next   = PRESSED;
                        deb_cnt_next = '0;
                        pulse_next   = 1'b1;
                    end else begin
                        deb_cnt_next = deb_cnt_inc;
                    end
                end
                PRESSED: begin
                    deb_cnt_next = '0;
                    if (!sync_p1[i]) begin
                        if (DEB_ONE == DEB_MAX) begin
                            state_next = IDLE;
                        end else begin
                            state_next   = DEB_RELEASE;
                            deb_cnt_next = DEB_ONE;
                        end
                    end
                end
                DEB_RELEASE: begin
                    if (sync_p1[i]) begin
                        // Bounce during release: return without a new strobe.
                        state_next   = PRESSED;
                        deb_cnt_next = '0;
                    end else if (deb_cnt_inc == DEB_MAX) begin
                        state_next   = IDLE;
                        deb_cnt_next = '0;
                    end else begin
                        deb_cnt_next = deb_cnt_inc;
                    end
                end
                default: begin
                    state_next   = IDLE;
                    deb_cnt_next = '0;
                end
            endcase
        end

        assign level        = (state == PRESSED) || (state == DEB_RELEASE);
        assign btn_level[i] = level;
        assign btn_pulse[i] = pulse_q;

`ifdef ACONDICIONADOR_LONG_PRESS_EN
        localparam int HW = $clog2(HOLD_CYCLES + 1);
        localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
        logic [HW-1:0] hold_cnt;

        // Hold counter: cleared on acceptance, counts while PRESSED,
        // frozen during release bounces, saturates at HOLD_CYCLES.
        always_ff @(posedge clk) begin
            if (reset) begin
                hold_cnt <= '0;
            end else if (pulse_next) begin
                hold_cnt <= '0;
            end else if (state == PRESSED && hold_cnt < HOLD_MAX) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end

        assign btn_long[i] = level && (hold_cnt >= HOLD_MAX);
`else
        assign btn_long[i] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_acondicionador_botones.sv
// Self-checking bench for acondicionador_botones (DEBOUNCE_CYCLES=4,
// HOLD_CYCLES=16). Expected outputs per edge are pushed into a queue as each
// raw value is driven, then popped and compared after the edge.
// Edge numbering inside each scenario: edge 1 is the first edge that samples
// the scenario's first raw value.
module tb_acondicionador_botones;

`ifdef ACONDICIONADOR_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn_raw;
    logic [3:0] btn_level;
    logic [3:0] btn_pulse;
    logic [3:0] btn_long;

    int total = 0;
    int bad   = 0;
    logic [11:0] exp_q[$];

    acondicionador_botones #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_raw(btn_raw),
        .btn_level(btn_level),
        .btn_pulse(btn_pulse),
        .btn_long(btn_long)
    );

    always #5 clk = ~clk;

    // Clean press: raw high on edges s..s+n-1, low otherwise.
    // Returns {level, pulse, long} expected after edge e.
    function automatic logic [2:0] press_exp(input int e, input int s, input int n);
        logic lv, pu, lg;
        if (n < 4) return 3'b000;
        lv = (e >= s + 5) && (e <= s + n + 4);
        pu = (e == s + 5);
        lg = LONG_EN && (e >= s + 21) && (e <= s + n + 4);
        return {lv, pu, lg};
    endfunction

    function automatic logic [11:0] pack(input logic [2:0] b0, input logic [2:0] b1,
                                         input logic [2:0] b2, input logic [2:0] b3);
        return {b3[2], b2[2], b1[2], b0[2],
                b3[1], b2[1], b1[1], b0[1],
                b3[0], b2[0], b1[0], b0[0]};
    endfunction

    // Drive one raw value before the next edge and queue its expectation.
    task automatic drive(input logic rst, input logic [3:0] raw, input logic [11:0] exp);
        @(negedge clk);
        reset   = rst;
        btn_raw = raw;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [11:0] got, want;
        for (int e = 1; e <= 6; e++) begin
            drive(e <= 3, (e <= 3) ? 4'hF : 4'h0, 12'h000);
            got  = {btn_level, btn_pulse, btn_long};
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL reset e=%0d got=%h want=%h", e, got, want);
            end
        end
    endtask

    task automatic test_glitch();
        logic [11:0] got, want;
        for (int e = 1; e <= 12; e++) begin
            drive(1'b0, (e <= 3) ? 4'b0100 : 4'b0000, 12'h000);
            got  = {btn_level, btn_pulse, btn_long};
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL glitch e=%0d got=%h want=%h", e, got, want);
            end
        end
    endtask

    task automatic test_press();
        logic [11:0] got, want;
        for (int e = 1; e <= 22; e++) begin
            drive(1'b0, (e <= 10) ? 4'b1000 : 4'b0000,
                  pack(3'b0, 3'b0, 3'b0, press_exp(e, 1, 10)));
            got  = {btn_level, btn_pulse, btn_long};
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL press e=%0d got=%h want=%h", e, got, want);
            end
        end
    endtask

    task automatic test_long_press();
        logic [11:0] got, want;
        for (int e = 1; e <= 42; e++) begin
            drive(1'b0, (e <= 30) ? 4'b0001 : 4'b0000,
                  pack(press_exp(e, 1, 30), 3'b0, 3'b0, 3'b0));
            got  = {btn_level, btn_pulse, btn_long};
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL long e=%0d got=%h want=%h", e, got, want);
            end
        end
    endtask

    // Bit1 held, 2-cycle low glitch on edges 13-14 after acceptance. The hold
    // count freezes for the two release-debounce edges, so long rises at 24.
    task automatic test_bounce();
        logic [11:0] got, want;
        logic        raw1, lv, pu, lg;
        for (int e = 1; e <= 40; e++) begin
            raw1 = (e <= 30) && !(e == 13 || e == 14);
            lv   = (e >= 6) && (e <= 35);
            pu   = (e == 6);
            lg   = LONG_EN && (e >= 24) && (e <= 35);
            drive(1'b0, {2'b00, raw1, 1'b0}, pack(3'b0, {lv, pu, lg}, 3'b0, 3'b0));
            got  = {btn_level, btn_pulse, btn_long};
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL bounce e=%0d got=%h want=%h", e, got, want);
            end
        end
    endtask

    // Bit2 held edges 1-20, reset asserted for edge 10 only.
    task automatic test_reset_mid_press();
        logic [11:0] got, want;
        logic [2:0]  b2;
        for (int e = 1; e <= 32; e++) begin
            if (e < 10)       b2 = press_exp(e, 1, 100);
            else if (e == 10) b2 = 3'b000;
            else              b2 = press_exp(e, 11, 10);
            drive(e == 10, (e <= 20) ? 4'b0100 : 4'b0000, pack(3'b0, 3'b0, b2, 3'b0));
            got  = {btn_level, btn_pulse, btn_long};
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL reset_mid e=%0d got=%h want=%h", e, got, want);
            end
        end
    endtask

    task automatic test_all_bits();
        logic [11:0] got, want;
        for (int e = 1; e <= 16; e++) begin
            drive(1'b0, (e <= 8) ? 4'hF : 4'h0,
                  pack(press_exp(e, 1, 8), press_exp(e, 1, 8),
                       press_exp(e, 1, 8), press_exp(e, 1, 8)));
            got  = {btn_level, btn_pulse, btn_long};
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL all_bits e=%0d got=%h want=%h", e, got, want);
            end
        end
    endtask

    // Staggered independent activity: bit0 s=1 n=8, bit1 s=3 n=5,
    // bit2 s=2 n=2 (rejected), bit3 s=2 n=12.
    task automatic test_independent();
        logic [11:0] got, want;
        logic [3:0]  raw;
        for (int e = 1; e <= 22; e++) begin
            raw[0] = (e >= 1) && (e <= 8);
            raw[1] = (e >= 3) && (e <= 7);
            raw[2] = (e >= 2) && (e <= 3);
            raw[3] = (e >= 2) && (e <= 13);
            drive(1'b0, raw, pack(press_exp(e, 1, 8), press_exp(e, 3, 5),
                                  press_exp(e, 2, 2), press_exp(e, 2, 12)));
            got  = {btn_level, btn_pulse, btn_long};
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL independent e=%0d got=%h want=%h", e, got, want);
            end
        end
    endtask

    initial begin
        reset   = 1'b1;
        btn_raw = 4'h0;
        test_reset();
        test_glitch();
        test_press();
        test_long_press();
        test_bounce();
        test_reset_mid_press();
        test_all_bits();
        test_independent();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
